// File: rtl/key_schedule_iter.sv
// Iterative AES-128/192/256 key expansion with a combinational round-key read port.
// Words are produced WORDS_PER_CYCLE per clock, chained within the cycle.
module key_schedule_iter #(
    parameter int WORDS_PER_CYCLE = 1,
    parameter int MAX_ROUND_KEYS  = 15
) (
    input  logic         clk_i,
    input  logic         reset_n_i,
    input  logic         key_v_i,
    output logic         key_ready_o,
    input  logic [0:255] key_i,
    input  logic [1:0]   key_len_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         error_o,
    input  logic [3:0]   rk_idx_i,
    output logic [127:0] rk_o,
    output logic         rk_v_o
);

    localparam int NW  = 4 * MAX_ROUND_KEYS;
    localparam int WPC = WORDS_PER_CYCLE;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] EXPAND = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{x, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    logic [1:0]  state;
    logic [5:0]  idx;
    logic [5:0]  nk;
    logic [5:0]  nwords;
    logic [3:0]  nr;
    logic [2:0]  kmax;
    logic [2:0]  kpos;
    logic [2:0]  kpos_n;
    logic [7:0]  rcon;
    logic [7:0]  rcon_n;
    logic        err_q;
    logic        accept;
    logic        last;
    logic [5:0]  rb;
    logic [31:0] w  [NW];
    logic [31:0] nw [WPC];
    logic        wr [WPC];

    assign accept = key_v_i && key_ready_o;
    assign nwords = {nr, 2'b00} + 6'd4;
    assign last   = (idx + 6'(WPC)) >= nwords;

    // kpos tracks (i mod Nk) so no divider is needed for the 192-bit case
    always_comb begin
        logic [7:0]  rc;
        logic [2:0]  pos;
        logic [31:0] prev;
        logic [31:0] temp;
        logic [5:0]  wi;
        rc   = rcon;
        pos  = kpos;
        prev = w[idx - 6'd1];
        temp = '0;
        wi   = '0;
        for (int j = 0; j < WPC; j++) begin
            wi   = idx + 6'(j);
            temp = prev;
            if (pos == 3'd0) begin
                temp = sub_word({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
                rc   = xtime(rc);
            end else if (kmax == 3'd7 && pos == 3'd4) begin
                temp = sub_word(temp);
            end
            nw[j] = w[wi - nk] ^ temp;
            wr[j] = wi < nwords;
            prev  = nw[j];
            pos   = (pos == kmax) ? 3'd0 : pos + 3'd1;
        end
        rcon_n = rc;
        kpos_n = pos;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state <= IDLE;
            err_q <= 1'b0;
            idx   <= '0;
            nk    <= '0;
            nr    <= '0;
            kmax  <= '0;
            kpos  <= '0;
            rcon  <= '0;
        end else begin
            err_q <= 1'b0;
            if (accept) begin
                case (key_len_i)
                    2'b00: begin nk <= 6'd4; kmax <= 3'd3; nr <= 4'd10; idx <= 6'd4; end
                    2'b01: begin nk <= 6'd6; kmax <= 3'd5; nr <= 4'd12; idx <= 6'd6; end
                    2'b10: begin nk <= 6'd8; kmax <= 3'd7; nr <= 4'd14; idx <= 6'd8; end
                    default: ;
                endcase
                kpos  <= 3'd0;
                rcon  <= 8'h01;
                state <= (key_len_i == 2'b11) ? IDLE : EXPAND;
                err_q <= (key_len_i == 2'b11);
            end else if (state == EXPAND) begin
                idx  <= idx + 6'(WPC);
                rcon <= rcon_n;
                kpos <= kpos_n;
                if (last) state <= DONE;
            end
        end
    end

    // schedule storage is deliberately not reset; reads are gated by done
    always_ff @(posedge clk_i) begin
        if (accept && key_len_i != 2'b11) begin
            for (int k = 0; k < 8; k++) w[k] <= key_i[32*k +: 32];
        end else if (state == EXPAND) begin
            for (int j = 0; j < WPC; j++) begin
                if (wr[j]) w[idx + 6'(j)] <= nw[j];
            end
        end
    end

    assign key_ready_o = (state != EXPAND);
    assign busy_o      = (state == EXPAND);
    assign done_o      = (state == DONE);
    assign error_o     = err_q;

    assign rb     = {rk_idx_i, 2'b00};
    assign rk_v_o = done_o && (rk_idx_i <= nr);
    assign rk_o   = rk_v_o ? {w[rb], w[rb + 6'd1], w[rb + 6'd2], w[rb + 6'd3]} : '0;

endmodule
